// File: rtl/selector_frame_loader.sv
// Byte-stream loader for the selector datapath. It parses a header byte and then
// operands A and B, sent MSB first, and holds the assembled set under a valid/ready handshake.
module selector_frame_loader #(
  parameter int         N_BITS   = 16,
  parameter int         N_BYTES  = N_BITS / 8,
  parameter logic [3:0] HDR_MARK = 4'hA
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_byte,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [N_BITS-1:0] o_dataA,
  output logic signed [N_BITS-1:0] o_dataB,
  output logic [1:0]               o_sel,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [7:0]               o_err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int             CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [N_BITS-1:0] data_a_q, data_a_d;
  logic signed [N_BITS-1:0] data_b_q, data_b_d;
  logic [1:0]               sel_q, sel_d;
  logic [7:0]               err_q, err_d;
  logic [N_BITS-1:0]        shift_a, shift_b;
  logic                     accept;
  logic                     hdr_ok;

  // A single-byte operand has nothing to shift, so it loads directly.
  generate
    if (N_BITS == 8) begin : g_direct
      assign shift_a = i_byte;
      assign shift_b = i_byte;
    end else begin : g_shift
      assign shift_a = {data_a_q[N_BITS-9:0], i_byte};
      assign shift_b = {data_b_q[N_BITS-9:0], i_byte};
    end
  endgenerate

  assign o_ready = (state_q != HOLD);
  assign accept  = i_valid & o_ready;
  assign hdr_ok  = (i_byte[7:4] == HDR_MARK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    sel_d    = sel_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            sel_d   = i_byte[1:0];
            state_d = LOAD_A;
            cnt_d   = '0;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          data_a_d = shift_a;
          if (cnt_q == LAST) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          data_b_d = shift_b;
          if (cnt_q == LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      sel_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  assign o_dataA   = data_a_q;
  assign o_dataB   = data_b_q;
  assign o_sel     = sel_q;
  assign o_valid   = (state_q == HOLD);
  assign o_err_cnt = err_q;

endmodule
